// File: rtl/block_vga_render.sv
// ============================================================================
// Module   : block_vga_render
// Purpose  : 640x480@60 VGA timing with a 3-stage block-map renderer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module block_vga_render #(
    parameter int BLK_SHIFT = 5,
    parameter int GRID      = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [4:0]  xBlockNum,
    output logic [4:0]  yBlockNum,
    input  logic [3:0]  BlockState,
    output logic        hs,
    output logic        vs,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] C_H_LAST    = 10'd799;
    localparam logic [9:0] C_V_LAST    = 10'd524;
    localparam logic [9:0] C_H_VIS     = 10'd640;
    localparam logic [9:0] C_V_VIS     = 10'd480;
    localparam logic [9:0] C_HS_BEG    = 10'd656;
    localparam logic [9:0] C_HS_END    = 10'd751;
    localparam logic [9:0] C_VS_BEG    = 10'd490;
    localparam logic [9:0] C_VS_END    = 10'd491;
    localparam logic [9:0] C_BLK_MASK  = 10'((1 << BLK_SHIFT) - 1);
    localparam logic [11:0] C_GRID_RGB = 12'h222;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [4:0]  x_blk_q, x_blk_d;
    logic [4:0]  y_blk_q, y_blk_d;
    logic        vis0_q, vis0_d;
    logic        grid0_q, grid0_d;
    logic        hs0_q, hs0_d;
    logic        vs0_q, vs0_d;
    logic        fs0_q, fs0_d;
    logic [3:0]  state1_q, state1_d;
    logic        vis1_q, vis1_d;
    logic        grid1_q, grid1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        fs1_q, fs1_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;

    logic [9:0]  w_h_blk;
    logic [9:0]  w_v_blk;
    logic        w_vis;

    always_comb begin
        h_cnt_d = (h_cnt_q == C_H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == C_H_LAST) begin
            v_cnt_d = (v_cnt_q == C_V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        // Stage 0: address the state register and capture pixel attributes
        w_vis   = (h_cnt_q < C_H_VIS) && (v_cnt_q < C_V_VIS);
        w_h_blk = h_cnt_q >> BLK_SHIFT;
        w_v_blk = v_cnt_q >> BLK_SHIFT;
        x_blk_d = w_vis ? w_h_blk[4:0] : 5'd0;
        y_blk_d = w_vis ? w_v_blk[4:0] : 5'd0;
        vis0_d  = w_vis;
        grid0_d = (GRID != 0) &&
                  (((h_cnt_q & C_BLK_MASK) == 10'd0) || ((v_cnt_q & C_BLK_MASK) == 10'd0));
        hs0_d   = !((h_cnt_q >= C_HS_BEG) && (h_cnt_q <= C_HS_END));
        vs0_d   = !((v_cnt_q >= C_VS_BEG) && (v_cnt_q <= C_VS_END));
        fs0_d   = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

        // Stage 1: state code returned for the stage-0 address
        state1_d = BlockState;
        vis1_d   = vis0_q;
        grid1_d  = grid0_q;
        hs1_d    = hs0_q;
        vs1_d    = vs0_q;
        fs1_d    = fs0_q;

        // Stage 2: colour lookup, blanking forces black, grid overrides the map
        rgb_d = 12'h000;
        if (vis1_q) begin
            if (grid1_q) begin
                rgb_d = C_GRID_RGB;
            end else begin
                case (state1_q)
                    4'd0:    rgb_d = 12'h000;
                    4'd1:    rgb_d = 12'h0F0;
                    4'd2:    rgb_d = 12'hFF0;
                    4'd3:    rgb_d = 12'hF00;
                    4'd4:    rgb_d = 12'h888;
                    default: rgb_d = 12'h00F;
                endcase
            end
        end
        hs_d = hs1_q;
        vs_d = vs1_q;
        fs_d = fs1_q;
    end

    // Sync stages reset to the inactive level so hs/vs never glitch after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q  <= 10'd0;
            v_cnt_q  <= 10'd0;
            x_blk_q  <= 5'd0;
            y_blk_q  <= 5'd0;
            vis0_q   <= 1'b0;
            grid0_q  <= 1'b0;
            hs0_q    <= 1'b1;
            vs0_q    <= 1'b1;
            fs0_q    <= 1'b0;
            state1_q <= 4'd0;
            vis1_q   <= 1'b0;
            grid1_q  <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            fs1_q    <= 1'b0;
            rgb_q    <= 12'h000;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            x_blk_q  <= x_blk_d;
            y_blk_q  <= y_blk_d;
            vis0_q   <= vis0_d;
            grid0_q  <= grid0_d;
            hs0_q    <= hs0_d;
            vs0_q    <= vs0_d;
            fs0_q    <= fs0_d;
            state1_q <= state1_d;
            vis1_q   <= vis1_d;
            grid1_q  <= grid1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            fs1_q    <= fs1_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
        end
    end

    assign xBlockNum   = x_blk_q;
    assign yBlockNum   = y_blk_q;
    assign rgb         = rgb_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_block_vga_render.sv
// ============================================================================
// Module   : tb_block_vga_render
// Purpose  : Bench for block_vga_render (GRID=0 and GRID=1 instances).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_block_vga_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  x0, y0, x1, y1;
    logic [3:0]  bs0, bs1;
    logic        hs0, vs0, hs1, vs1, fs0, fs1;
    logic [11:0] rgb0, rgb1;
    logic [3:0]  mem [0:299];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // State register: combinational read of the block currently addressed
    assign bs0 = (x0 < 5'd20 && y0 < 5'd15) ? mem[int'(y0) * 20 + int'(x0)] : 4'd0;
    assign bs1 = (x1 < 5'd20 && y1 < 5'd15) ? mem[int'(y1) * 20 + int'(x1)] : 4'd0;

    block_vga_render #(.BLK_SHIFT(5), .GRID(0)) u_dut0 (
        .clk(clk), .rst(rst), .xBlockNum(x0), .yBlockNum(y0), .BlockState(bs0),
        .hs(hs0), .vs(vs0), .rgb(rgb0), .frame_start(fs0)
    );

    block_vga_render #(.BLK_SHIFT(5), .GRID(1)) u_dut1 (
        .clk(clk), .rst(rst), .xBlockNum(x1), .yBlockNum(y1), .BlockState(bs1),
        .hs(hs1), .vs(vs1), .rgb(rgb1), .frame_start(fs1)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [11:0] colour(input logic [3:0] s);
        case (s)
            4'd0:    return 12'h000;
            4'd1:    return 12'h0F0;
            4'd2:    return 12'hFF0;
            4'd3:    return 12'hF00;
            4'd4:    return 12'h888;
            default: return 12'h00F;
        endcase
    endfunction

    // Expected pixel for the p-th counter position since reset release
    function automatic logic [11:0] exp_rgb(input int p, input bit grid);
        int h, v;
        h = p % 800;
        v = (p / 800) % 525;
        if (h >= 640 || v >= 480) return 12'h000;
        if (grid && ((h % 32) == 0 || (v % 32) == 0)) return 12'h222;
        return colour(mem[(v / 32) * 20 + (h / 32)]);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " x0"}, 0, 32'(x0), 32'd0);
        chk({tag, " y0"}, 0, 32'(y0), 32'd0);
        chk({tag, " rgb0"}, 0, 32'(rgb0), 32'd0);
        chk({tag, " hs0"}, 0, 32'(hs0), 32'd1);
        chk({tag, " vs0"}, 0, 32'(vs0), 32'd1);
        chk({tag, " fs0"}, 0, 32'(fs0), 32'd0);
        chk({tag, " x1"}, 0, 32'(x1), 32'd0);
        chk({tag, " y1"}, 0, 32'(y1), 32'd0);
        chk({tag, " rgb1"}, 0, 32'(rgb1), 32'd0);
        chk({tag, " hs1"}, 0, 32'(hs1), 32'd1);
        chk({tag, " vs1"}, 0, 32'(vs1), 32'd1);
        chk({tag, " fs1"}, 0, 32'(fs1), 32'd0);
    endtask

    // Sampled 1 time unit after the k-th rising edge since reset release
    task automatic check_cycle(input int k);
        int p, h, v;
        logic [4:0]  xe, ye;
        logic [11:0] re0, re1;
        logic        hse, vse, fse;
        xe = 5'd0; ye = 5'd0;
        if (k >= 1) begin
            p = k - 1;
            h = p % 800;
            v = (p / 800) % 525;
            if (h < 640 && v < 480) begin
                xe = 5'(h / 32);
                ye = 5'(v / 32);
            end
        end
        chk("xblk0", k, 32'(x0), 32'(xe));
        chk("yblk0", k, 32'(y0), 32'(ye));
        chk("xblk1", k, 32'(x1), 32'(xe));
        chk("yblk1", k, 32'(y1), 32'(ye));
        re0 = 12'h000; re1 = 12'h000; hse = 1'b1; vse = 1'b1; fse = 1'b0;
        if (k >= 3) begin
            p = k - 3;
            h = p % 800;
            v = (p / 800) % 525;
            re0 = exp_rgb(p, 1'b0);
            re1 = exp_rgb(p, 1'b1);
            hse = !(h >= 656 && h <= 751);
            vse = !(v >= 490 && v <= 491);
            fse = (h == 0 && v == 0);
        end
        chk("rgb0", k, 32'(rgb0), 32'(re0));
        chk("rgb1", k, 32'(rgb1), 32'(re1));
        chk("hs0", k, 32'(hs0), 32'(hse));
        chk("vs0", k, 32'(vs0), 32'(vse));
        chk("fs0", k, 32'(fs0), 32'(fse));
        chk("hs1", k, 32'(hs1), 32'(hse));
        chk("fs1", k, 32'(fs1), 32'(fse));
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 300; i++) mem[i] = 4'($urandom_range(0, 15));
        // Row 0 sweeps every state code; block (0,0)=3 also feeds blanking
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        mem[0]  = 4'd3;
        mem[41] = 4'd2;
        mem[21] = 4'd1;
        mem[22] = 4'd1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset_hold");

        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 65 * 800 + 300; k++) begin
            @(posedge clk);
            #1;
            check_cycle(k);
            if (k == 64 * 800 + 33 + 1) begin
                chk("blk_x_at_33_64", k, 32'(x0), 32'd1);
                chk("blk_y_at_33_64", k, 32'(y0), 32'd2);
            end
            if (k == 64 * 800 + 33 + 3) chk("rgb_head_at_33_64", k, 32'(rgb0), 32'hFF0);
            if (k == 40 * 800 + 64 + 3) chk("grid_line_64_40", k, 32'(rgb1), 32'h222);
            if (k == 40 * 800 + 65 + 3) chk("grid_body_65_40", k, 32'(rgb1), 32'h0F0);
        end

        // Mid-line asynchronous reset: outputs must clear before the next edge
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async_reset");
        @(posedge clk);
        #1;
        chk_reset("reset_held_edge");

        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            check_cycle(k);
            if (k == 3) chk("first_frame_start", k, 32'(fs0), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
